// File: rtl/amiq_stim_player.sv
// Multi-channel stimulus sequencer: per-channel FIFOs of (value, delay) pairs replayed concurrently on start.
// Optional feature macro: AMIQ_STIM_PLAYER_LOOP_EN (non-destructive replay plus the loop request).
module amiq_stim_player #(
  parameter int NCH   = 3,
  parameter int W     = 1,
  parameter int DEPTH = 32,
  parameter int DLY_W = 8,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [CH_W-1:0]  load_ch,
  input  logic [W-1:0]     load_value,
  input  logic [DLY_W-1:0] load_delay,
  input  logic             start,
  input  logic             flush,
  input  logic             loop,
  output logic [NCH*W-1:0] out,
  output logic [NCH-1:0]   out_vld,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t         r_state, w_state_nxt;
  logic           r_first, r_busy, r_done, r_err;
  logic           w_run, w_go, w_flush, w_acc, w_ch_ok, w_full_sel;
  logic           w_all_fin, w_restart;
  logic [NCH-1:0] w_full, w_fin;

  assign w_ch_ok   = {1'b0, load_ch} < (CH_W+1)'(NCH);
  assign w_all_fin = w_run && (&w_fin);

`ifdef AMIQ_STIM_PLAYER_LOOP_EN
  assign w_restart = w_all_fin && loop;
`else
  logic w_unused_loop;
  assign w_unused_loop = loop;
  assign w_restart     = 1'b0;
`endif

  // Full flag of the addressed channel; out-of-range channels never stall.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_full_sel = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (load_ch == CH_W'(i)) w_full_sel = w_full[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start && !flush) w_state_nxt = S_RUN;
      S_RUN:   if (w_all_fin && !w_restart) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_run      = (r_state == S_RUN);
    w_go       = (r_state == S_IDLE) && start && !flush;
    w_flush    = (r_state == S_IDLE) && flush;
    load_ready = (r_state == S_IDLE) && !start && !flush && (!w_ch_ok || !w_full_sel);
    w_acc      = load_valid && load_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_first <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_first <= w_go;
      r_busy  <= w_run;
      r_done  <= w_all_fin && !w_restart;
      r_err   <= r_err | (w_acc && !w_ch_ok);
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [W+DLY_W-1:0] r_mem [DEPTH];
    logic [AW:0]        r_rd, r_wr;
    logic [DLY_W-1:0]   r_cnt;
    logic               r_act, r_vld;
    logic [W-1:0]       r_out;
    logic [AW:0]        w_raddr;
    logic [W+DLY_W-1:0] w_rdata;
    logic               w_wr, w_pop, w_empty;

`ifdef AMIQ_STIM_PLAYER_LOOP_EN
    logic [AW:0] r_rd0;

    // Run-start read position, restored when a pass completes.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)          r_rd0 <= '0;
      else if (w_flush) r_rd0 <= '0;
      else if (w_go)    r_rd0 <= r_rd;
    end

    assign w_raddr = w_restart ? r_rd0 : r_rd;
`else
    assign w_raddr = r_rd;
`endif

    assign w_empty   = (r_rd == r_wr);
    assign w_full[g] = (r_rd[AW] != r_wr[AW]) && (r_rd[AW-1:0] == r_wr[AW-1:0]);
    assign w_wr      = w_acc && (load_ch == CH_W'(g));
    assign w_rdata   = r_mem[w_raddr[AW-1:0]];
    assign w_pop     = w_run && (w_raddr != r_wr) &&
                       (r_first || w_restart || (r_act && r_cnt == '0));
    assign w_fin[g]  = r_first ? w_empty : (!r_act || (r_cnt == '0 && w_empty));

    // NOTE: the storage array has no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr[AW-1:0]] <= {load_value, load_delay};
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rd  <= '0;
        r_wr  <= '0;
        r_cnt <= '0;
        r_act <= 1'b0;
        r_out <= '0;
        r_vld <= 1'b0;
      end else begin
        r_vld <= w_pop;
        if (w_flush) begin
          r_rd <= '0;
          r_wr <= '0;
        end else begin
          if (w_wr) r_wr <= r_wr + 1'b1;
          if (w_pop) r_rd <= w_raddr + 1'b1;
`ifdef AMIQ_STIM_PLAYER_LOOP_EN
          else if (w_all_fin) r_rd <= r_rd0;
`endif
        end
        // Counter holds the remaining extra cycles of the entry on the output.
        if (w_pop) begin
          r_out <= w_rdata[W+DLY_W-1:DLY_W];
          r_cnt <= w_rdata[DLY_W-1:0];
          r_act <= 1'b1;
        end else if (r_act && r_cnt != '0) begin
          r_cnt <= r_cnt - 1'b1;
        end else begin
          r_act <= 1'b0;
        end
      end
    end

    assign out[g*W +: W] = r_out;
    assign out_vld[g]    = r_vld;
  end

endmodule

// File: tb/tb_amiq_stim_player.sv
// Self-checking bench for amiq_stim_player: table of playback scenarios, a per-cycle scoreboard
// built from a bench-side FIFO model, and hand-written sequences for control corner cases.
module tb_amiq_stim_player;

  localparam int NCH = 3;

  typedef struct {
    int ch;
    int val;
    int dly;
  } pair_t;

  typedef struct {
    int    np;
    pair_t p[6];
    int    exp_done;
  } scen_t;

  typedef struct {
    logic [NCH-1:0] out;
    logic [NCH-1:0] vld;
    logic           busy;
    logic           done;
  } snap_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           load_valid = 1'b0;
  logic           load_ready;
  logic [1:0]     load_ch = '0;
  logic [0:0]     load_value = '0;
  logic [7:0]     load_delay = '0;
  logic           start = 1'b0;
  logic           flush = 1'b0;
  logic           loop = 1'b0;
  logic [NCH-1:0] out;
  logic [NCH-1:0] out_vld;
  logic           busy, done, err;

  int             n_checks = 0;
  int             n_pass = 0;
  logic [NCH-1:0] cur_out = '0;
  pair_t          mq [NCH][$];
  scen_t          tbl [5];

  amiq_stim_player #(.NCH(NCH), .W(1), .DEPTH(4), .DLY_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_ch    (load_ch),
    .load_value (load_value),
    .load_delay (load_delay),
    .start      (start),
    .flush      (flush),
    .loop       (loop),
    .out        (out),
    .out_vld    (out_vld),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic pair_t pr(input int c, input int v, input int d);
    pair_t p;
    p.ch  = c;
    p.val = v;
    p.dly = d;
    return p;
  endfunction

  task automatic clear_model();
    for (int c = 0; c < NCH; c++) mq[c].delete();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    clear_model();
  endtask

  task automatic load(input int c, input int v, input int d);
    int n = 0;
    load_valid = 1'b1;
    load_ch    = 2'(c);
    load_value = 1'(v);
    load_delay = 8'(d);
    #1;
    while (!load_ready && n < 20) begin
      step();
      n++;
    end
    check($sformatf("load_ready ch%0d", c), load_ready, 1);
    step();
    load_valid = 1'b0;
    if (c < NCH) mq[c].push_back(pr(c, v, d));
  endtask

  // Builds the expected per-cycle outputs from the model FIFOs, pulses start, then compares each cycle.
  task automatic play(input string name, input int exp_done, input int restart_at);
    snap_t sq[$];
    snap_t s;
    int    nt [NCH];
    int    idx [NCH];
    int    tend = 1;
    int    seen = 0;
    int    t = 0;
    for (int c = 0; c < NCH; c++) begin
      int f = 1;
      for (int k = 0; k < mq[c].size(); k++) f += mq[c][k].dly + 1;
      if (f > tend) tend = f;
      nt[c]  = 1;
      idx[c] = 0;
    end
    for (int ts = 1; ts <= tend + 1; ts++) begin
      s.vld = '0;
      for (int c = 0; c < NCH; c++) begin
        if (idx[c] < mq[c].size() && nt[c] == ts) begin
          cur_out[c] = 1'(mq[c][idx[c]].val);
          s.vld[c]   = 1'b1;
          nt[c]     += mq[c][idx[c]].dly + 1;
          idx[c]++;
        end
      end
      s.out  = cur_out;
      s.busy = (ts <= tend);
      s.done = (ts == tend);
      sq.push_back(s);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    while (sq.size() > 0) begin
      step();
      t++;
      s = sq.pop_front();
      check($sformatf("%s@t%0d {out,vld,busy,done}", name, t),
            {out, out_vld, busy, done}, {s.out, s.vld, s.busy, s.done});
      if (t == 1 && tend > 1) check($sformatf("%s ready_in_run", name), load_ready, 0);
      if (done && seen == 0) seen = t;
      start = (t == restart_at);
    end
    start = 1'b0;
    check($sformatf("%s done_cycle", name), 64'(seen), 64'(exp_done));
`ifndef AMIQ_STIM_PLAYER_LOOP_EN
    clear_model();
`endif
  endtask

  initial begin
    for (int i = 0; i < 5; i++) tbl[i].np = 0;
    tbl[0].np = 3; tbl[0].exp_done = 7;
    tbl[0].p[0] = pr(0, 1, 2); tbl[0].p[1] = pr(0, 0, 0); tbl[0].p[2] = pr(0, 1, 1);
    tbl[1].np = 3; tbl[1].exp_done = 7;
    tbl[1].p[0] = pr(0, 1, 5); tbl[1].p[1] = pr(1, 1, 0); tbl[1].p[2] = pr(1, 0, 0);
    tbl[2].np = 5; tbl[2].exp_done = 6;
    tbl[2].p[0] = pr(0, 0, 1); tbl[2].p[1] = pr(1, 1, 3); tbl[2].p[2] = pr(2, 1, 0);
    tbl[2].p[3] = pr(2, 0, 2); tbl[2].p[4] = pr(2, 1, 0);
    tbl[3].np = 1; tbl[3].exp_done = 257;
    tbl[3].p[0] = pr(2, 1, 255);
    tbl[4].np = 0; tbl[4].exp_done = 1;

    // Reset asserted between edges must act at once.
    #2 rst = 1'b1;
    #1 check("reset_values {out,vld,busy,done,err,ready}",
             {out, out_vld, busy, done, err, load_ready}, {3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1});
    #8 rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      do_flush();
      for (int k = 0; k < tbl[i].np; k++) load(tbl[i].p[k].ch, tbl[i].p[k].val, tbl[i].p[k].dly);
      play($sformatf("scen%0d", i), tbl[i].exp_done, 0);
    end

    // flush beats start in the same cycle and empties the FIFOs.
    do_flush();
    load(0, 1, 0);
    flush = 1'b1;
    start = 1'b1;
    #1 check("flush_blocks_ready", load_ready, 0);
    step();
    flush = 1'b0;
    start = 1'b0;
    clear_model();
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("flush_wins_idle%0d {busy,vld}", i), {busy, out_vld}, 4'b0000);
    end
    play("after_flush", 1, 0);

    // A start pulse inside RUN must not disturb playback.
    do_flush();
    load(0, 1, 3);
    load(0, 0, 0);
    play("start_in_run", 6, 1);

    // Full channel stalls alone; an invalid channel is accepted and sets the sticky error.
    do_flush();
    for (int k = 0; k < 4; k++) load(1, (k + 1) % 2, 0);
    load_valid = 1'b1;
    load_ch    = 2'd1;
    load_value = 1'b1;
    load_delay = 8'd0;
    #1 check("full_stall", load_ready, 0);
    step();
    check("full_stall_hold", load_ready, 0);
    load_ch    = 2'd0;
    load_value = 1'b0;
    load_delay = 8'd2;
    #1 check("other_ch_ready", load_ready, 1);
    step();
    mq[0].push_back(pr(0, 0, 2));
    load_ch = 2'd3;
    #1 check("bad_ch_ready", load_ready, 1);
    step();
    load_valid = 1'b0;
    check("err_set", err, 1);
    play("full_play", 5, 0);
    check("err_sticky", err, 1);

`ifdef AMIQ_STIM_PLAYER_LOOP_EN
    do_flush();
    load(0, 1, 0);
    load(0, 0, 0);
    loop  = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      step();
      check($sformatf("loop@t%0d {out0,vld0,busy,done}", t),
            {out[0], out_vld[0], busy, done}, {1'(t % 2), 1'b1, 1'b1, 1'b0});
    end
    loop = 1'b0;
    step();
    check("loop_exit {out0,vld0,busy,done}", {out[0], out_vld[0], busy, done}, 4'b0011);
    step();
    check("loop_exit_idle {busy,done}", {busy, done}, 2'b00);
    cur_out[0] = 1'b0;
    play("loop_replay", 3, 0);
`else
    do_flush();
    load(0, 1, 0);
    loop = 1'b1;
    play("loop_ignored", 2, 0);
    play("empty_after_run", 1, 0);
    loop = 1'b0;
`endif

    // Reset in the middle of a run.
    do_flush();
    load(0, 1, 9);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #3 rst = 1'b1;
    #1 check("async_reset_mid_run {out,vld,busy,done,err}",
             {out, out_vld, busy, done, err}, 9'd0);
    cur_out = '0;
    clear_model();
    #2 rst = 1'b0;
    step();
    check("ready_after_reset", load_ready, 1);
    play("post_reset_empty", 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/amiq_stim_player.md
# amiq_stim_player

Synthesisable, parametrised multi-channel stimulus sequencer that replaces the per-signal `drive_*` tasks of the mux testbench. A loader writes (value, delay) pairs into per-channel FIFOs. On `start`, every channel replays its pairs concurrently: each value is driven onto that channel's output, held, then the next pair is applied. The block sits between the socket/DPI stimulus decoder and the DUT inputs (e.g. `in0`, `in1`, `sel` of `amiq_mux2_1`).

## Interface
Parameters:
- `NCH`, 3: number of output channels (≥1).
- `W`, 1: value width per channel.
- `DEPTH`, 32: FIFO entries per channel (power of two).
- `DLY_W`, 8: delay field width, unsigned, in clock cycles.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load_valid`  in  1  loader offers a pair.
- `load_ready`  out  1  loader handshake; a pair is accepted when `load_valid && load_ready`.
- `load_ch`  in  `$clog2(NCH)` (min 1)  target channel.
- `load_value`  in  `W`  value to drive.
- `load_delay`  in  `DLY_W`  extra hold cycles after the value is applied.
- `start`  in  1  begin playback; a single-cycle pulse.
- `flush`  in  1  empty all FIFOs; honoured only while idle.
- `loop`  in  1  replay request; sampled at completion; honoured only with the macro defined.
- `out`  out  `NCH*W`  channel *i* drives bits `[i*W +: W]`.
- `out_vld`  out  `NCH`  1-cycle pulse on the cycle channel *i*'s `out` takes a new entry.
- `busy`  out  1  playback in progress.
- `done`  out  1  1-cycle pulse when playback completes.
- `err`  out  1  sticky; set when `load_ch >= NCH` is accepted; cleared only by `rst`.

## Operation
- Global FSM has two states: IDLE and RUN.
- **IDLE**
  - `load_ready = !start && !flush && !full[load_ch]`; a combinational path from `load_ch` is allowed.
  - An accepted pair is written to `load_ch`'s FIFO.
  - If `load_ch >= NCH`, the pair is accepted (`load_ready = 1`), discarded, and `err` is set.
  - `flush` resets all FIFO pointers. When `flush` and `start` are high together, `flush` wins and `start` is ignored.
  - `start` moves the FSM to RUN.
- **RUN**
  - `load_ready = 0`; `start` and `flush` are ignored.
  - Each non-empty channel pops entry 0 on the first RUN cycle, then applies entry *k+1* exactly `delay_k + 1` cycles after entry *k*.
  - A channel finishes `delay_last + 1` cycles after its last entry is applied.
  - An empty channel is finished immediately and its `out` keeps its previous value.
- **Completion**: when all channels are finished, `done` pulses, `busy` drops in the same cycle, and the FSM returns to IDLE.
- **Outputs**: `out` holds its last value between runs; it never returns to 0 except on reset.
- **Per-channel state**: FIFO memory, read/write pointers with one extra wrap bit for full/empty, a `DLY_W`-bit down-counter and an active flag.
- **Delay arithmetic**: delay is unsigned. `delay = 0` gives a one-cycle hold; the maximum hold is `2^DLY_W` cycles.

## Timing
- **Reset values**: `out = 0`, `out_vld = 0`, `busy = 0`, `done = 0`, `err = 0`, `load_ready` as per IDLE, all FIFOs empty, FSM in IDLE.
- `start` sampled at edge *c* → `busy = 1`, the first `out` update and the `out_vld` pulses appear after edge *c+1*.
- **All channels empty at start**: `done` pulses after edge *c+1*, `busy` stays high for that one cycle only, and there are no `out_vld` pulses.
- **FIFO full**: `load_ready = 0` for that channel only; other channels still accept.
- **Reset mid-run**: asynchronous return to the reset values; contents are lost and `done` is not pulsed.

## Configuration
- **`AMIQ_STIM_PLAYER_LOOP_EN` defined**
  - Read pointers are non-destructive during RUN and rewind to the run-start position at completion; entries are retained.
  - If `loop = 1` in the completion cycle: `done` is not pulsed, `busy` stays high, and entry 0 of every channel is re-applied on the next cycle.
  - If `loop = 0`: `done` pulses and the FIFOs still hold the pattern for another `start`.
  - Only `flush` empties the FIFOs.
- **Macro undefined**
  - Reads are destructive and the FIFOs are empty after every run.
  - The `loop` port is present but ignored.

## Test plan
- **Reset values**: reset asserted mid-clock → all outputs at reset values immediately, without waiting for an edge.
- **Single channel, `NCH=3`, `W=1`**: load ch0 {(1,2),(0,0),(1,1)}, pulse `start` at cycle 10 → ch0 `out` = 1 at cycle 11, 0 at 14, 1 at 15; `done` at cycle 17; `out_vld[0]` pulses at 11, 14 and 15.
- **Concurrent channels**: ch0 {(1,5)}, ch1 {(1,0),(0,0)}, ch2 empty, start at cycle 0 → `done` at cycle 7; ch1 returns to 0 at cycle 2; ch2 `out` unchanged.
- **Full and invalid channel**: with `DEPTH=4`, load 5 pairs to ch1 → the 5th stalls with `load_ready = 0` while ch0 loads still succeed; `load_ch = 3` accepted → `err = 1` and stays high until reset.
- **Control precedence**: `start` with all channels empty → `done` one cycle later; `flush` and `start` in the same cycle → FIFOs emptied, no `busy`; a `start` during RUN has no effect.
- **Loop (macro defined)**: ch0 {(1,0),(0,0)} with `loop = 1` → ch0 toggles 1,0,1,0,… with no `done`; drop `loop` → `done` after the current pass; `start` again → the same pattern replays.
